// File: rtl/menu_overlay_ctl_if.sv
// menu_overlay_ctl_if: mixer-side and RAM-port-B-side signals of the menu overlay sequencer.
interface menu_overlay_ctl_if;
    logic        enable;
    logic        line_start;
    logic [7:0]  line_y;
    logic        ram_ce;
    logic [10:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        pix_req;
    logic [7:0]  pix_x;
    logic        pix_valid;
    logic        pix_on;
    logic        pix_hl;
    modport master (
        output enable, line_start, line_y, ram_dout, pix_req, pix_x,
        input  ram_ce, ram_addr, busy, pix_valid, pix_on, pix_hl
    );
    modport slave (
        input  enable, line_start, line_y, ram_dout, pix_req, pix_x,
        output ram_ce, ram_addr, busy, pix_valid, pix_on, pix_hl
    );
endinterface

// File: rtl/menu_overlay_ctl.sv
// menu_overlay_ctl: per-scanline text/font fetch from the menu RAM into a line buffer,
// answering pixel queries from the mixer one cycle later.
module menu_overlay_ctl #(
    parameter int          COLS      = 30,
    parameter int          ROWS      = 20,
    parameter logic [10:0] TEXT_BASE = 11'h000,
    parameter logic [10:0] FONT_BASE = 11'h400
) (
    input logic               clk,
    input logic               reset,
    menu_overlay_ctl_if.slave bus
);
    localparam int LINES = ROWS * 8;
    localparam int WIDTH = COLS * 8;

    typedef enum logic [1:0] {IDLE, RD_CHAR, RD_FONT, STORE} state_t;

    state_t      r_state;
    logic [7:0]  r_ly;
    logic [4:0]  r_col;
    logic        r_code_hl;
    logic        r_line_active;
    logic [7:0]  r_buf [0:31];
    logic [31:0] r_hl;
    logic        r_pix_valid;
    logic        r_pix_on;
    logic        r_pix_hl;

    logic        w_fetching;
    logic        w_restart;
    logic        w_line_ok;
    logic        w_pix_ok;
    logic [4:0]  w_cell;
    logic [10:0] w_text;
    logic [10:0] w_font;

    assign w_fetching = r_state != IDLE;
    assign w_restart  = bus.enable & bus.line_start;
    assign w_line_ok  = {24'd0, bus.line_y} < LINES;
    assign w_cell     = bus.pix_x[7:3];
    assign w_pix_ok   = bus.enable & r_line_active & ~w_fetching & ({24'd0, bus.pix_x} < WIDTH);
    assign w_text     = TEXT_BASE + 11'({r_ly[7:3], 5'd0}) + 11'(r_col);
    // The glyph address depends on the code arriving this very cycle, so it cannot be registered.
    assign w_font     = FONT_BASE + 11'({bus.ram_dout[6:0], r_ly[2:0]});

    always_comb begin
        bus.ram_ce    = bus.enable & (r_state == RD_CHAR || r_state == RD_FONT);
        bus.ram_addr  = !bus.ram_ce ? 11'd0 : (r_state == RD_FONT ? w_font : w_text);
        bus.busy      = bus.enable & w_fetching;
        bus.pix_valid = bus.enable & r_pix_valid;
        bus.pix_on    = bus.enable & r_pix_on;
        bus.pix_hl    = bus.enable & r_pix_hl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ly          <= 8'd0;
            r_col         <= 5'd0;
            r_code_hl     <= 1'b0;
            r_line_active <= 1'b0;
        end else if (w_restart) begin
            r_ly          <= bus.line_y;
            r_col         <= 5'd0;
            r_line_active <= 1'b0;
            r_state       <= w_line_ok ? RD_CHAR : IDLE;
        end else if (!bus.enable) begin
            if (w_fetching) r_line_active <= 1'b0;
            r_state <= IDLE;
        end else begin
            case (r_state)
                RD_CHAR: r_state <= RD_FONT;
                RD_FONT: begin
                    r_code_hl <= bus.ram_dout[7];
                    r_state   <= STORE;
                end
                STORE: begin
                    if (r_col == 5'(COLS - 1)) begin
                        r_line_active <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_col   <= r_col + 5'd1;
                        r_state <= RD_CHAR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Highlighted cells are stored pre-inverted so the pixel path is a plain bit select.
    always_ff @(posedge clk) begin
        if (r_state == STORE && !w_restart) begin
            r_buf[r_col] <= bus.ram_dout ^ {8{r_code_hl}};
            r_hl[r_col]  <= r_code_hl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_valid <= 1'b0;
            r_pix_on    <= 1'b0;
            r_pix_hl    <= 1'b0;
        end else begin
            r_pix_valid <= bus.pix_req & bus.enable;
            r_pix_on    <= bus.pix_req & w_pix_ok & r_buf[w_cell][bus.pix_x[2:0]];
            r_pix_hl    <= bus.pix_req & w_pix_ok & r_hl[w_cell];
        end
    end
endmodule

// File: tb/tb_menu_overlay_ctl.sv
// tb_menu_overlay_ctl: randomized bench with a RAM model, a cycle-level fetch model and a
// pixel scoreboard fed by the stimulus and drained by an independent monitor.
module tb_menu_overlay_ctl;
    localparam int          COLS = 30;
    localparam int          ROWS = 20;
    localparam logic [10:0] TB   = 11'h000;
    localparam logic [10:0] FB   = 11'h400;

    typedef struct {int due; logic on; logic hl;} exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [7:0] mem [0:2047];
    exp_t       sb[$];

    logic       m_fetch;
    logic       m_line;
    logic [7:0] m_ly;
    int         m_k;
    int         m_ready;

    menu_overlay_ctl_if bus();

    menu_overlay_ctl #(.COLS(COLS), .ROWS(ROWS), .TEXT_BASE(TB), .FONT_BASE(FB)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.ram_ce) bus.ram_dout <= mem[bus.ram_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] code_at(input logic [7:0] ly, input int c);
        logic [10:0] a;
        a = TB + 11'((int'(ly) / 8) * 32 + c);
        return mem[a];
    endfunction

    function automatic logic [7:0] glyph(input logic [7:0] code, input logic [7:0] ly);
        logic [10:0] a;
        a = FB + 11'((int'(code) % 128) * 8 + int'(ly) % 8);
        return mem[a];
    endfunction

    function automatic logic [1:0] pix_model(input logic [7:0] x);
        logic [7:0] c;
        logic [7:0] g;
        if (!(m_line && cyc >= m_ready && bus.enable) || int'(x) >= COLS * 8) return 2'b00;
        c = code_at(m_ly, int'(x) / 8);
        g = glyph(c, m_ly);
        return {g[int'(x) % 8] ^ c[7], c[7]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input cycle: the query is judged against the state before this cycle's line_start.
    task automatic cycle_in(input logic ls, input logic [7:0] ly, input logic q, input logic [7:0] x);
        logic [1:0] e;
        bus.line_start = ls;
        bus.line_y     = ly;
        bus.pix_req    = q;
        bus.pix_x      = x;
        if (q) begin
            e = pix_model(x);
            sb.push_back('{cyc + 1, e[1], e[0]});
        end
        tick();
        if (ls && bus.enable) begin
            m_ly    = ly;
            m_k     = cyc - 1;
            m_fetch = int'(ly) < ROWS * 8;
            m_line  = m_fetch;
            m_ready = m_k + 3 * COLS + 1;
        end
        bus.line_start = 1'b0;
        bus.pix_req    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_in(1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic query_range(input int lo, input int hi);
        for (int x = lo; x <= hi; x++) cycle_in(1'b0, 8'd0, 1'b1, 8'(x));
        idle(2);
    endtask

    always @(negedge clk) begin
        logic       eb;
        logic       ece;
        int         ph;
        int         col;
        logic [7:0] c;
        logic [10:0] ea;
        if (chk) begin
            eb  = m_fetch && bus.enable && !reset && cyc > m_k && cyc <= m_k + 3 * COLS;
            ph  = eb ? (cyc - m_k - 1) % 3 : 2;
            col = eb ? (cyc - m_k - 1) / 3 : 0;
            ece = eb && ph != 2;
            check("busy", 32'(bus.busy), 32'(eb));
            check("ram_ce", 32'(bus.ram_ce), 32'(ece));
            if (ece) begin
                c  = code_at(m_ly, col);
                ea = ph == 0 ? TB + 11'((int'(m_ly) / 8) * 32 + col)
                             : FB + 11'((int'(c) % 128) * 8 + int'(m_ly) % 8);
                check("ram_addr", 32'(bus.ram_addr), 32'(ea));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("pix_valid", 32'(bus.pix_valid), 32'd1);
                check("pix_on", 32'(bus.pix_on), 32'(sb[0].on));
                check("pix_hl", 32'(bus.pix_hl), 32'(sb[0].hl));
                void'(sb.pop_front());
            end else begin
                check("pix_idle", {29'd0, bus.pix_valid, bus.pix_on, bus.pix_hl}, 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        mem[0]      = 8'h41;
        mem[11'h608] = 8'h0C;
        bus.enable     = 1'b0;
        bus.line_start = 1'b0;
        bus.line_y     = 8'd0;
        bus.pix_req    = 1'b0;
        bus.pix_x      = 8'd0;
        m_fetch = 1'b0;
        m_line  = 1'b0;
        m_ly    = 8'd0;
        m_k     = -1000;
        m_ready = 0;
        tick();
        chk = 1'b1;
        check("reset_addr", 32'(bus.ram_addr), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);
        bus.enable = 1'b1;
        idle(2);

        // Line 0: 'A' in cell 0, then full row and right-edge queries.
        cycle_in(1'b1, 8'd0, 1'b0, 8'd0);
        idle(3 * COLS + 1);
        query_range(0, 7);
        query_range(232, 255);

        // Same line with the highlighted code 0xC1 in cell 0.
        mem[0] = 8'hC1;
        cycle_in(1'b1, 8'd0, 1'b0, 8'd0);
        idle(3 * COLS + 1);
        query_range(0, 15);

        // First inactive line: nothing fetched, nothing shown.
        cycle_in(1'b1, 8'd160, 1'b0, 8'd0);
        idle(4);
        query_range(0, 7);

        // Last active line: row 19, font row 7.
        cycle_in(1'b1, 8'd159, 1'b0, 8'd0);
        @(negedge clk);
        check("first_text_addr_159", 32'(bus.ram_addr), 32'h260);
        #1;
        tick();
        idle(3 * COLS);
        for (int i = 0; i < 20; i++) cycle_in(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)));
        idle(2);

        // line_start on cycle 40 of a fetch restarts at the new row.
        cycle_in(1'b1, 8'd37, 1'b0, 8'd0);
        idle(39);
        cycle_in(1'b1, 8'd90, 1'b1, 8'd5);
        idle(3 * COLS);
        for (int i = 0; i < 20; i++) cycle_in(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)));
        idle(2);

        // Reset on cycle 40 of a fetch.
        cycle_in(1'b1, 8'd64, 1'b0, 8'd0);
        idle(39);
        reset   = 1'b1;
        m_fetch = 1'b0;
        m_line  = 1'b0;
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_ce", 32'(bus.ram_ce), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);
        query_range(0, 7);

        // enable dropped mid-fetch, later raised without a new line.
        cycle_in(1'b1, 8'd8, 1'b0, 8'd0);
        idle(20);
        bus.enable = 1'b0;
        m_fetch    = 1'b0;
        m_line     = 1'b0;
        idle(100);
        bus.enable = 1'b1;
        idle(2);
        query_range(0, 15);

        // Random traffic: overlapping line starts and queries, including the same cycle.
        for (int i = 0; i < 3000; i++)
            cycle_in($urandom_range(0, 149) == 0, 8'($urandom_range(0, 179)),
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        idle(4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
